// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage register with exception sideband; optional skid via PIPE_STAGE_SKID_EN
module pipe_stage_buf #(
    parameter int          DW         = 64,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          irq,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [31:0]   in_pc,
    input  logic [4:0]    in_exc,
    input  logic          in_bd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_pc4,
    output logic [4:0]    out_exc,
    output logic          out_bd,
    output logic [1:0]    occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_MAIN  = 2'd1;
`ifdef PIPE_STAGE_SKID_EN
    localparam logic [1:0] ST_FULL  = 2'd2;
`endif

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic          push;
    logic          pop;
    logic          load_out;
    logic [DW-1:0] ld_data;
    logic [31:0]   ld_pc;
    logic [31:0]   ld_pc4;
    logic [4:0]    ld_exc;
    logic          ld_bd;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = state;

`ifdef PIPE_STAGE_SKID_EN
    logic          from_skid;
    logic          load_skid;
    logic          ready_q;
    logic [DW-1:0] skid_data;
    logic [31:0]   skid_pc;
    logic [31:0]   skid_pc4;
    logic [4:0]    skid_exc;
    logic          skid_bd;

    // Registered ready: the only path into in_ready is the state register.
    assign in_ready = ready_q;
`else
    // Without a skid slot the stage can only accept when the output frees up this cycle.
    assign in_ready = !out_valid | out_ready;
`endif

    // Next-state and load decisions for the EMPTY/MAIN(/FULL) occupancy machine.
    always_comb begin
        next_state = state;
        load_out   = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        from_skid  = 1'b0;
        load_skid  = 1'b0;
`endif
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    next_state = ST_MAIN;
                    load_out   = 1'b1;
                end
            end
            ST_MAIN: begin
                if (push && pop) begin
                    load_out = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                end else if (push) begin
                    next_state = ST_FULL;
                    load_skid  = 1'b1;
`endif
                end else if (pop) begin
                    next_state = ST_EMPTY;
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_FULL: begin
                if (pop) begin
                    next_state = ST_MAIN;
                    load_out   = 1'b1;
                    from_skid  = 1'b1;
                end
            end
`endif
            default: next_state = ST_EMPTY;
        endcase
    end

    // Source for the output register: the skid entry when draining, otherwise the input.
    always_comb begin
        ld_data = in_data;
        ld_pc   = in_pc;
        ld_pc4  = in_pc + 32'd4;
        ld_exc  = in_exc;
        ld_bd   = in_bd;
`ifdef PIPE_STAGE_SKID_EN
        if (from_skid) begin
            ld_data = skid_data;
            ld_pc   = skid_pc;
            ld_pc4  = skid_pc4;
            ld_exc  = skid_exc;
            ld_bd   = skid_bd;
        end
`endif
    end

    // Output register and state; irq beats flush beats the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pc    <= '0;
            out_pc4   <= '0;
            out_exc   <= '0;
            out_bd    <= 1'b0;
        end else if (irq) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pc    <= HANDLER_PC;
            out_pc4   <= HANDLER_PC + 32'd4;
            out_exc   <= '0;
            out_bd    <= 1'b0;
        end else if (flush) begin
            // PC fields are left alone so the last macro-PC stays visible.
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_exc   <= '0;
            out_bd    <= 1'b0;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != ST_EMPTY);
            if (load_out) begin
                out_data <= ld_data;
                out_pc   <= ld_pc;
                out_pc4  <= ld_pc4;
                out_exc  <= ld_exc;
                out_bd   <= ld_bd;
            end
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid slot captures the entry that arrives while the output is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_data <= '0;
            skid_pc   <= '0;
            skid_pc4  <= '0;
            skid_exc  <= '0;
            skid_bd   <= 1'b0;
        end else if (load_skid && !irq && !flush) begin
            skid_data <= in_data;
            skid_pc   <= in_pc;
            skid_pc4  <= in_pc + 32'd4;
            skid_exc  <= in_exc;
            skid_bd   <= in_bd;
        end
    end

    // Ready is precomputed from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b1;
        end else if (irq || flush) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (next_state != ST_FULL);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          irq;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [31:0]   in_pc;
    logic [4:0]    in_exc;
    logic          in_bd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc4;
    logic [4:0]    out_exc;
    logic          out_bd;
    logic [1:0]    occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_buf #(.DW(DW), .HANDLER_PC(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .flush(flush), .irq(irq),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pc(out_pc), .out_pc4(out_pc4), .out_exc(out_exc), .out_bd(out_bd),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] exc, input logic bd);
        in_valid = v;
        in_pc    = pc;
        in_data  = {32'hDA7A_0000, pc};
        in_exc   = exc;
        in_bd    = bd;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; irq = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data, 0);
        check("rst_pc",    out_pc, 0);
        check("rst_pc4",   out_pc4, 0);
        check("rst_exc",   out_exc, 0);
        check("rst_bd",    out_bd, 0);
        check("rst_occ",   occupancy, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;

        // Streaming, one entry per cycle, 1-cycle latency
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h3000 + 32'(4 * k), 5'd0, 1'b0);
            step();
            check("str_valid", out_valid, 1);
            check("str_pc",    out_pc, 32'h3000 + 32'(4 * k));
            check("str_pc4",   out_pc4, 32'h3004 + 32'(4 * k));
            check("str_data",  out_data, {32'hDA7A_0000, 32'h3000 + 32'(4 * k)});
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check("str_drain", out_valid, 0);
        check("str_occ0",  occupancy, 0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0A00, 5'd0, 1'b0);
        step();
        check("bp_a_pc",  out_pc, 32'h0A00);
        check("bp_a_occ", occupancy, 1);
        drive(1'b1, 32'h0000_0B00, 5'd0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        check("bp_rdy_main", in_ready, 1);
        step();
        check("bp_occ2",  occupancy, 2);
        check("bp_rdy0",  in_ready, 0);
        check("bp_pcA",   out_pc, 32'h0A00);
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check("bp_hold",  out_pc, 32'h0A00);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_reg", in_ready, 0);
        step();
        check("bp_pcB",   out_pc, 32'h0B00);
        check("bp_pc4B",  out_pc4, 32'h0B04);
        check("bp_occ1",  occupancy, 1);
        step();
        check("bp_empty", out_valid, 0);
`else
        #1;
        check("bp_rdy0",  in_ready, 0);
        step();
        check("bp_hold",  out_pc, 32'h0A00);
        check("bp_occ1",  occupancy, 1);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_comb", in_ready, 1);
        step();
        check("bp_pcB",   out_pc, 32'h0B00);
        check("bp_pc4B",  out_pc4, 32'h0B04);
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check("bp_empty", out_valid, 0);
`endif

        // irq with flush and push at the same edge, stage as full as it can get
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0C00, 5'd3, 1'b1);
        step();
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 32'h0000_0C04, 5'd3, 1'b1);
        step();
        check("irq_pre_occ", occupancy, 2);
`endif
        irq = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h0000_0D00, 5'd7, 1'b1);
        step();
        irq = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check("irq_valid", out_valid, 0);
        check("irq_pc",    out_pc, 32'h4180);
        check("irq_pc4",   out_pc4, 32'h4184);
        check("irq_exc",   out_exc, 0);
        check("irq_bd",    out_bd, 0);
        check("irq_data",  out_data, 0);
        check("irq_occ",   occupancy, 0);
        check("irq_rdy",   in_ready, 1);

        // flush drops the incoming entry, PC holds
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0E00, 5'd4, 1'b0);
        step();
        check("fl_pre_pc", out_pc, 32'h0E00);
        check("fl_pre_exc", out_exc, 4);
        flush = 1'b1;
        drive(1'b1, 32'h0000_0F00, 5'd12, 1'b1);
        step();
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_exc",   out_exc, 0);
        check("fl_bd",    out_bd, 0);
        check("fl_pc",    out_pc, 32'h0E00);
        check("fl_occ",   occupancy, 0);
        step();
        check("fl_push_valid", out_valid, 1);
        check("fl_push_exc",   out_exc, 12);
        check("fl_push_bd",    out_bd, 1);
        check("fl_push_pc",    out_pc, 32'h0F00);

        // PC+4 wraps
        drive(1'b1, 32'hFFFF_FFFC, 5'd0, 1'b0);
        step();
        check("wrap_pc",  out_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", out_pc4, 32'h0000_0000);
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0500, 5'd9, 1'b1);
        step();
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 32'h0000_0504, 5'd9, 1'b1);
        step();
        check("ar_pre_occ", occupancy, 2);
`else
        check("ar_pre_occ", occupancy, 1);
`endif
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_data",  out_data, 0);
        check("ar_pc",    out_pc, 0);
        check("ar_pc4",   out_pc4, 0);
        check("ar_exc",   out_exc, 0);
        check("ar_bd",    out_bd, 0);
        check("ar_occ",   occupancy, 0);
        check("ar_rdy",   in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline register for the five-stage MIPS core, the generalised successor to the fixed-field stage registers. It carries an arbitrary-width datapath payload plus the precise-exception sideband (PC, PC+4, ExcCode, branch-delay flag) with a valid/ready handshake instead of a bare write-enable. It adds an optional two-entry skid buffer, so that upstream `in_ready` is a registered signal. An interrupt flush loads the handler PC as a bubble, so macro-PC tracking stays correct.

## Interface
- `DW`, 64, payload width (instruction word + operands), ≥1
- `HANDLER_PC`, 32'h0000_4180, PC loaded on `irq`
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  discard all held entries (branch squash / eret)
- `irq`  in  1  interrupt flush; loads handler-PC bubble
- `in_valid`  in  1  upstream entry valid
- `in_ready`  out  1  block accepts an entry this cycle
- `in_data`  in  DW  payload
- `in_pc`  in  32  entry PC
- `in_exc`  in  5  ExcCode (0 = none)
- `in_bd`  in  1  entry is in a branch-delay slot
- `out_valid`  out  1  output entry valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  DW; `out_pc` out 32; `out_pc4` out 32; `out_exc` out 5; `out_bd` out 1
- `occupancy`  out  2  entries held (0..2)

## Operation
- Reset (`reset`=0, async): `out_valid`=0, `out_data`=0, `out_pc`=0, `out_pc4`=0, `out_exc`=0, `out_bd`=0, `occupancy`=0, `in_ready`=1, state EMPTY.
- Transfer in: `in_valid & in_ready` at a rising edge. Transfer out: `out_valid & out_ready`.
- `out_pc4` = `out_pc` + 32'd4, modulo 2^32 (32'hFFFF_FFFC → 0); registered with the entry, never computed combinationally from the output.
- States: EMPTY (occ 0), MAIN (occ 1, entry in output reg), FULL (occ 2, second entry in skid reg).
  - EMPTY: push → MAIN.
  - MAIN: push without pop → FULL. Push with pop → MAIN (output reg reloads). Pop only → EMPTY.
  - FULL: pop → MAIN, skid moves to output reg. `in_ready`=0, so no push.
- `in_ready` = (state != FULL), taken from a register.
- `flush` (priority over handshake): next state EMPTY, `out_valid`=0, `out_exc`=0, `out_bd`=0, occupancy 0. The PC fields hold their values. The input this cycle is dropped.
- `irq` (priority over `flush` and handshake): next state EMPTY, `out_valid`=0, `out_data`=0, `out_exc`=0, `out_bd`=0, `out_pc`=`HANDLER_PC`, `out_pc4`=`HANDLER_PC`+4.
- An entry with `in_exc`≠0 is carried unchanged. The block never alters ExcCode.
- `out_*` fields are stable while `out_valid & !out_ready`.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 entry/cycle when `out_ready` is held high.
- Downstream stall depth absorbed: 1 extra entry (skid).
- `flush`/`irq` take effect on the same edge they are sampled. Outputs show the result in the following cycle.
- Reset deassertion is synchronised externally. The first transfer is possible on the first edge after release.
- All outputs are registered. There is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: behaviour as above (depth 2, registered `in_ready`).
- Not defined:
  - No skid register. States are EMPTY/MAIN only; `occupancy` ≤ 1.
  - `in_ready` = `!out_valid | out_ready`, which is combinational from `out_ready`.
  - Latency, flush and irq behaviour are unchanged.

## Test plan
- Reset mid-stream with occ=2, `reset`=0 asynchronously between edges → all outputs 0 immediately, `in_ready`=1, occupancy 0.
- Streaming: 8 entries `in_pc`=0x3000+4k, `out_ready`=1 → `out_pc` sequence 0x3000..0x301C, one per cycle after 1-cycle latency, `out_pc4` = `out_pc`+4.
- Backpressure (skid): push A, B with `out_ready`=0 → occupancy 2, `in_ready`=0, `out_pc`=A. Raise `out_ready` → A then B in consecutive cycles. Without `PIPE_STAGE_SKID_EN`: B is held at input, `in_ready`=0 combinationally.
- irq with FULL and simultaneous `flush` and push → next cycle `out_valid`=0, `out_pc`=0x4180, `out_pc4`=0x4184, `out_exc`=0, occupancy 0.
- flush while `in_valid`=1, `in_exc`=5'd12, `in_bd`=1 → entry dropped, `out_valid`=0, `out_exc`=0, `out_bd`=0. Next push with exc 12, bd 1 → appears with `out_exc`=12, `out_bd`=1.
- Wrap: `in_pc`=32'hFFFF_FFFC → `out_pc4`=32'h0000_0000.
